// File: rtl/rom_port_arbiter_if.sv
// Memory-side port of rom_port_arbiter: request/ack handshake toward the ROM memory controller.
interface rom_port_arbiter_if #(
    parameter int AW = 18
);
    logic          MEMRQ;
    logic          MEMWE;
    logic [AW-1:0] MEMA;
    logic [7:0]    MEMWD;
    logic          MEMACK;
    logic [7:0]    MEMRD;

    modport master (
        output MEMRQ, MEMWE, MEMA, MEMWD,
        input  MEMACK, MEMRD
    );

    modport slave (
        input  MEMRQ, MEMWE, MEMA, MEMWD,
        output MEMACK, MEMRD
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one program-ROM memory port between Z80 reads and the ROM download writer.
// Optional macro ROM_CACHE_EN: keep the read tag valid across CPURD deassertion.
module rom_port_arbiter #(
    parameter int            AW        = 18,
    parameter logic [AW-1:0] BANK_BASE = 'h10000
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          CPURD,
    input  logic [15:0]   CPUAD,
    input  logic [2:0]    ROMBK,
    output logic          ROMDV,
    output logic [7:0]    ROMDT,
    output logic          CPUWAIT,
    input  logic          DLEN,
    input  logic          DLWR,
    input  logic [AW-1:0] DLAD,
    input  logic [7:0]    DLDT,
    output logic          DLOVF,
    rom_port_arbiter_if.master mem
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] pa;
    logic [AW-1:0] rd_pa;
    logic          rd_val;
    logic          hit;
    logic [AW-1:0] wb_addr;
    logic [7:0]    wb_data;
    logic          wb_full;
    logic          dl_load;
    logic          issue_rd, issue_wr, rd_done, wr_done;

    always_comb begin
        ROMDV = (CPUAD < 16'hE000);
        if (CPUAD < 16'hC000)
            pa = AW'(CPUAD);
        else
            pa = BANK_BASE + AW'({ROMBK, CPUAD[12:0]});
        hit     = rd_val && (rd_pa == pa);
        CPUWAIT = CPURD & ROMDV & ~hit;
        dl_load = DLEN & DLWR & ~wb_full;
    end

    // A download strobe arriving in IDLE holds off a read miss so the write goes first.
    always_comb begin
        state_nx = state;
        issue_rd = 1'b0;
        issue_wr = 1'b0;
        rd_done  = 1'b0;
        wr_done  = 1'b0;
        case (state)
            IDLE: begin
                if (wb_full) begin
                    state_nx = WRITE;
                    issue_wr = 1'b1;
                end else if (CPUWAIT && !dl_load) begin
                    state_nx = READ;
                    issue_rd = 1'b1;
                end
            end
            READ: begin
                if (mem.MEMACK) begin
                    state_nx = IDLE;
                    rd_done  = 1'b1;
                end
            end
            WRITE: begin
                if (mem.MEMACK) begin
                    state_nx = IDLE;
                    wr_done  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem.MEMRQ <= 1'b0;
            mem.MEMWE <= 1'b0;
            mem.MEMA  <= '0;
            mem.MEMWD <= '0;
        end else if (issue_wr) begin
            mem.MEMRQ <= 1'b1;
            mem.MEMWE <= 1'b1;
            mem.MEMA  <= wb_addr;
            mem.MEMWD <= wb_data;
        end else if (issue_rd) begin
            mem.MEMRQ <= 1'b1;
            mem.MEMWE <= 1'b0;
            mem.MEMA  <= pa;
        end else if (rd_done || wr_done) begin
            mem.MEMRQ <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wb_full <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            DLOVF   <= 1'b0;
        end else begin
            if (DLEN && DLWR && wb_full)
                DLOVF <= 1'b1;
            if (dl_load) begin
                wb_full <= 1'b1;
                wb_addr <= DLAD;
                wb_data <= DLDT;
            end else if (wr_done) begin
                wb_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_pa  <= '0;
            rd_val <= 1'b0;
            ROMDT  <= '0;
        end else if (issue_rd) begin
            rd_pa  <= pa;
            rd_val <= 1'b0;
        end else if (rd_done) begin
            ROMDT  <= mem.MEMRD;
            rd_val <= 1'b1;
        end else if (wr_done && (wb_addr == rd_pa)) begin
            rd_val <= 1'b0;
        end
`ifdef ROM_CACHE_EN
`else
        else if (!CPURD) begin
            rd_val <= 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed, table-driven bench for rom_port_arbiter; expectations follow ROM_CACHE_EN when defined.
module tb_rom_port_arbiter;

`ifdef ROM_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CPURD;
    logic [15:0] CPUAD;
    logic [2:0]  ROMBK;
    logic        ROMDV;
    logic [7:0]  ROMDT;
    logic        CPUWAIT;
    logic        DLEN;
    logic        DLWR;
    logic [17:0] DLAD;
    logic [7:0]  DLDT;
    logic        DLOVF;

    rom_port_arbiter_if #(.AW(18)) mem_bus ();

    rom_port_arbiter #(.AW(18), .BANK_BASE(18'h10000)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CPURD(CPURD), .CPUAD(CPUAD), .ROMBK(ROMBK),
        .ROMDV(ROMDV), .ROMDT(ROMDT), .CPUWAIT(CPUWAIT), .DLEN(DLEN), .DLWR(DLWR),
        .DLAD(DLAD), .DLDT(DLDT), .DLOVF(DLOVF), .mem(mem_bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic [15:0] ad;
        logic [2:0]  bk;
        logic        dlen;
        logic        dlwr;
        logic [17:0] dlad;
        logic [7:0]  dldt;
        logic        ack;
        logic [7:0]  mrd;
        logic        x_dv;
        logic        x_wt;
        logic        x_rq;
        logic        x_we;
        logic [17:0] x_a;
        logic [7:0]  x_wd;
        logic [7:0]  x_dt;
        logic        x_ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rd, input logic [15:0] ad, input logic [2:0] bk,
                       input logic dlen, input logic dlwr, input logic [17:0] dlad,
                       input logic [7:0] dldt, input logic ack, input logic [7:0] mrd,
                       input logic x_dv, input logic x_wt, input logic x_rq, input logic x_we,
                       input logic [17:0] x_a, input logic [7:0] x_wd, input logic [7:0] x_dt,
                       input logic x_ovf);
        vec_t v;
        v.rd = rd; v.ad = ad; v.bk = bk; v.dlen = dlen; v.dlwr = dlwr; v.dlad = dlad;
        v.dldt = dldt; v.ack = ack; v.mrd = mrd; v.x_dv = x_dv; v.x_wt = x_wt;
        v.x_rq = x_rq; v.x_we = x_we; v.x_a = x_a; v.x_wd = x_wd; v.x_dt = x_dt;
        v.x_ovf = x_ovf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %h expected %h", name, row, got, exp);
        end
    endtask

    initial begin
        logic       nc;
        logic [7:0] dt25;
        nc   = !CACHE;
        dt25 = CACHE ? 8'hC3 : 8'hE7;

        //   rd  ad        bk  dlen dlwr dlad       dldt  ack mrd     dv wt  rq  we  a          wd     dt     ovf
        add(0, 16'h0000, 0, 0, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h00000, 8'h00, 8'h00, 0); // 0 reset state
        add(1, 16'hC123, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  0,  0, 18'h00000, 8'h00, 8'h00, 0); // 1 banked miss
        add(1, 16'hC123, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  1,  0, 18'h1A123, 8'h00, 8'h00, 0);
        add(1, 16'hC123, 5, 0, 0, 18'h0,     8'h00, 1, 8'hA5,  1, 1,  1,  0, 18'h1A123, 8'h00, 8'h00, 0);
        add(1, 16'hC123, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h1A123, 8'h00, 8'hA5, 0); // 4 wait falls
        add(0, 16'hC123, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h1A123, 8'h00, 8'hA5, 0);
        add(1, 16'hE044, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  0, 0,  0,  0, 18'h1A123, 8'h00, 8'hA5, 0); // 6 outside ROM
        add(1, 16'hE044, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  0, 0,  0,  0, 18'h1A123, 8'h00, 8'hA5, 0);
        add(0, 16'hE044, 5, 1, 1, 18'h00010, 8'h3C, 0, 8'h00,  0, 0,  0,  0, 18'h1A123, 8'h00, 8'hA5, 0); // 8 download
        add(0, 16'hE044, 5, 1, 1, 18'h00020, 8'h77, 0, 8'h00,  0, 0,  0,  0, 18'h1A123, 8'h00, 8'hA5, 0); // 9 overflow
        add(0, 16'hE044, 5, 1, 0, 18'h0,     8'h00, 0, 8'h00,  0, 0,  1,  1, 18'h00010, 8'h3C, 8'hA5, 1);
        add(0, 16'hE044, 5, 1, 0, 18'h0,     8'h00, 1, 8'h00,  0, 0,  1,  1, 18'h00010, 8'h3C, 8'hA5, 1);
        add(0, 16'hE044, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  0, 0,  0,  1, 18'h00010, 8'h3C, 8'hA5, 1); // 12 no 2nd write
        add(0, 16'hE044, 5, 0, 0, 18'h0,     8'h00, 1, 8'hFF,  0, 0,  0,  1, 18'h00010, 8'h3C, 8'hA5, 1); // 13 stray ack
        add(0, 16'hE044, 5, 0, 0, 18'h0,     8'h00, 0, 8'h00,  0, 0,  0,  1, 18'h00010, 8'h3C, 8'hA5, 1);
        add(1, 16'h0100, 0, 1, 1, 18'h00200, 8'h5A, 0, 8'h00,  1, 1,  0,  1, 18'h00010, 8'h3C, 8'hA5, 1); // 15 read+write
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  0,  1, 18'h00010, 8'h3C, 8'hA5, 1);
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 1, 8'h00,  1, 1,  1,  1, 18'h00200, 8'h5A, 8'hA5, 1);
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  0,  1, 18'h00200, 8'h5A, 8'hA5, 1); // 18 idle gap
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 1, 8'hC3,  1, 1,  1,  0, 18'h00100, 8'h5A, 8'hA5, 1);
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h00100, 8'h5A, 8'hC3, 1);
        add(0, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h00100, 8'h5A, 8'hC3, 1); // 21 CPURD low
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, nc, 0,  0, 18'h00100, 8'h5A, 8'hC3, 1); // 22 re-read
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, nc, nc, 0, 18'h00100, 8'h5A, 8'hC3, 1);
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 1, 8'hE7,  1, nc, nc, 0, 18'h00100, 8'h5A, 8'hC3, 1);
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h00100, 8'h5A, dt25,  1);
        add(0, 16'h0100, 0, 1, 1, 18'h00100, 8'h11, 0, 8'h00,  1, 0,  0,  0, 18'h00100, 8'h5A, dt25,  1); // 26 write 0100
        add(0, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h00100, 8'h5A, dt25,  1);
        add(0, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 1, 8'h00,  1, 0,  1,  1, 18'h00100, 8'h11, dt25,  1);
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  0,  1, 18'h00100, 8'h11, dt25,  1); // 29 invalidated
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 1, 8'h22,  1, 1,  1,  0, 18'h00100, 8'h11, dt25,  1);
        add(1, 16'h0100, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h00100, 8'h11, 8'h22, 1);
        add(1, 16'hDFFF, 7, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  0,  0, 18'h00100, 8'h11, 8'h22, 1); // 32 top of window
        add(1, 16'hDFFF, 7, 1, 0, 18'h0,     8'h00, 1, 8'h99,  1, 1,  1,  0, 18'h1FFFF, 8'h11, 8'h22, 1);
        add(1, 16'hDFFF, 7, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h1FFFF, 8'h11, 8'h99, 1);
        add(1, 16'hBFFF, 7, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  0,  0, 18'h1FFFF, 8'h11, 8'h99, 1); // 35 top of flat
        add(1, 16'hC000, 0, 1, 0, 18'h0,     8'h00, 1, 8'h44,  1, 1,  1,  0, 18'h0BFFF, 8'h11, 8'h99, 1); // 36 addr moves
        add(1, 16'hC000, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 1,  0,  0, 18'h0BFFF, 8'h11, 8'h44, 1);
        add(1, 16'hC000, 0, 1, 0, 18'h0,     8'h00, 1, 8'h55,  1, 1,  1,  0, 18'h10000, 8'h11, 8'h44, 1);
        add(1, 16'hC000, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  1, 0,  0,  0, 18'h10000, 8'h11, 8'h55, 1);
        add(1, 16'hE000, 0, 1, 0, 18'h0,     8'h00, 0, 8'h00,  0, 0,  0,  0, 18'h10000, 8'h11, 8'h55, 1); // 40 E000 edge

        RESET_N = 1'b0; CPURD = 1'b0; CPUAD = '0; ROMBK = '0;
        DLEN = 1'b0; DLWR = 1'b0; DLAD = '0; DLDT = '0;
        mem_bus.MEMACK = 1'b0; mem_bus.MEMRD = '0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            CPURD = vecs[i].rd;   CPUAD = vecs[i].ad;   ROMBK = vecs[i].bk;
            DLEN  = vecs[i].dlen; DLWR  = vecs[i].dlwr; DLAD  = vecs[i].dlad;
            DLDT  = vecs[i].dldt;
            mem_bus.MEMACK = vecs[i].ack; mem_bus.MEMRD = vecs[i].mrd;
            #2;
            chk("ROMDV",   i, 32'(ROMDV),         32'(vecs[i].x_dv));
            chk("CPUWAIT", i, 32'(CPUWAIT),       32'(vecs[i].x_wt));
            chk("MEMRQ",   i, 32'(mem_bus.MEMRQ), 32'(vecs[i].x_rq));
            chk("MEMWE",   i, 32'(mem_bus.MEMWE), 32'(vecs[i].x_we));
            chk("MEMA",    i, 32'(mem_bus.MEMA),  32'(vecs[i].x_a));
            chk("MEMWD",   i, 32'(mem_bus.MEMWD), 32'(vecs[i].x_wd));
            chk("ROMDT",   i, 32'(ROMDT),         32'(vecs[i].x_dt));
            chk("DLOVF",   i, 32'(DLOVF),         32'(vecs[i].x_ovf));
        end

        // Reset asserted while a read is outstanding.
        @(negedge CLK);
        CPURD = 1'b1; CPUAD = 16'h0000; ROMBK = '0; DLEN = 1'b0; DLWR = 1'b0;
        mem_bus.MEMACK = 1'b0;
        @(negedge CLK);
        chk("midread_MEMRQ", 100, 32'(mem_bus.MEMRQ), 32'd1);
        chk("midread_MEMA",  100, 32'(mem_bus.MEMA),  32'h00000);
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_MEMRQ", 101, 32'(mem_bus.MEMRQ), 32'd0);
        chk("rst_MEMWD", 101, 32'(mem_bus.MEMWD), 32'h00);
        chk("rst_ROMDT", 101, 32'(ROMDT),         32'h00);
        chk("rst_DLOVF", 101, 32'(DLOVF),         32'd0);
        chk("rst_WAIT",  101, 32'(CPUWAIT),       32'd1);
        repeat (2) @(negedge CLK);
        chk("rst_hold_MEMRQ", 102, 32'(mem_bus.MEMRQ), 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rst_reissue_MEMRQ", 103, 32'(mem_bus.MEMRQ), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
